// File: rtl/dmem_access_unit.sv
// Byte-addressed load/store front end for the RAMHelper 64-bit data port.
// Define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats; otherwise they are rejected.
module dmem_access_unit #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_ren,
    output logic [63:0] ram_rIdx,
    input  logic [63:0] ram_rdata,
    output logic [63:0] ram_wIdx,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    output logic        ram_wen
);

    localparam int unsigned XLEN = 64;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [2:0]        off_q, off_d;
    logic [XLEN-1:0]   idx_q, idx_d;
    logic              split_q, split_d;
    logic [XLEN-1:0]   wdata1_q, wdata1_d;
    logic [7:0]        be1_q, be1_d;
    logic [XLEN-1:0]   word0_q, word0_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              ram_ren_q, ram_ren_d;
    logic              ram_wen_q, ram_wen_d;
    logic [XLEN-1:0]   ram_ridx_q, ram_ridx_d;
    logic [XLEN-1:0]   ram_widx_q, ram_widx_d;
    logic [XLEN-1:0]   ram_wdata_q, ram_wdata_d;
    logic [XLEN-1:0]   ram_wmask_q, ram_wmask_d;

    // Incoming request decode: word index, byte offset, boundary crossing.
    logic [XLEN-1:0]   in_rel;
    logic [2:0]        in_off;
    logic [XLEN-1:0]   in_idx;
    logic [3:0]        in_nbytes;
    logic              in_split;
    logic              in_below;
    logic [15:0]       in_be;
    logic [2*XLEN-1:0] in_wide;

    always_comb begin
        in_rel    = req_addr - BASE_ADDR;
        in_off    = in_rel[2:0];
        in_idx    = XLEN'(in_rel[XLEN-1:3]);
        in_nbytes = 4'd1 << req_size;
        in_split  = (4'(in_off) + in_nbytes) > 4'd8;
        in_below  = req_addr < BASE_ADDR;
        in_be     = ((16'd1 << in_nbytes) - 16'd1) << in_off;
        in_wide   = {64'd0, req_wdata} << {in_off, 3'b000};
    end

    function automatic logic [XLEN-1:0] byte_mask(input logic [7:0] be);
        logic [XLEN-1:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // Align the (possibly two-word) read data, then truncate and extend.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] w0, input logic [XLEN-1:0] w1,
                                                    input logic [2:0] off, input logic [1:0] size,
                                                    input logic sgn);
        logic [XLEN-1:0] v;
        v = XLEN'({w1, w0} >> {off, 3'b000});
        case (size)
            2'd0:    return sgn ? {{56{v[7]}}, v[7:0]}   : {56'd0, v[7:0]};
            2'd1:    return sgn ? {{48{v[15]}}, v[15:0]} : {48'd0, v[15:0]};
            2'd2:    return sgn ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
            default: return v;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        wen_d        = wen_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        off_d        = off_q;
        idx_d        = idx_q;
        split_d      = split_q;
        wdata1_d     = wdata1_q;
        be1_d        = be1_q;
        word0_d      = word0_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ram_ren_d    = 1'b0;
        ram_wen_d    = 1'b0;
        ram_ridx_d   = '0;
        ram_widx_d   = '0;
        ram_wdata_d  = '0;
        ram_wmask_d  = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d       = req_wen;
                    size_d      = req_size;
                    sgn_d       = req_signed;
                    off_d       = in_off;
                    idx_d       = in_idx;
                    split_d     = in_split;
                    wdata1_d    = in_wide[2*XLEN-1:XLEN];
                    be1_d       = in_be[15:8];
                    req_ready_d = 1'b0;
                    if (in_below || (in_split && !SPLIT_EN)) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = BEAT0;
                        if (req_wen) begin
                            ram_wen_d   = 1'b1;
                            ram_widx_d  = in_idx;
                            ram_wdata_d = in_wide[XLEN-1:0];
                            ram_wmask_d = byte_mask(in_be[7:0]);
                        end else begin
                            ram_ren_d  = 1'b1;
                            ram_ridx_d = in_idx;
                        end
                    end
                end
            end
            BEAT0: begin
                if (!wen_q) word0_d = ram_rdata;
                if (split_q) begin
                    state_d = BEAT1;
                    if (wen_q) begin
                        ram_wen_d   = 1'b1;
                        ram_widx_d  = idx_q + 64'd1;
                        ram_wdata_d = wdata1_q;
                        ram_wmask_d = byte_mask(be1_q);
                    end else begin
                        ram_ren_d  = 1'b1;
                        ram_ridx_d = idx_q + 64'd1;
                    end
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = wen_q ? '0 : load_extend(ram_rdata, '0, off_q, size_q, sgn_q);
                end
            end
            BEAT1: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = wen_q ? '0 : load_extend(word0_q, ram_rdata, off_q, size_q, sgn_q);
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wen_q        <= 1'b0;
            size_q       <= '0;
            sgn_q        <= 1'b0;
            off_q        <= '0;
            idx_q        <= '0;
            split_q      <= 1'b0;
            wdata1_q     <= '0;
            be1_q        <= '0;
            word0_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
            ram_ridx_q   <= '0;
            ram_widx_q   <= '0;
            ram_wdata_q  <= '0;
            ram_wmask_q  <= '0;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            off_q        <= off_d;
            idx_q        <= idx_d;
            split_q      <= split_d;
            wdata1_q     <= wdata1_d;
            be1_q        <= be1_d;
            word0_q      <= word0_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_ren_q    <= ram_ren_d;
            ram_wen_q    <= ram_wen_d;
            ram_ridx_q   <= ram_ridx_d;
            ram_widx_q   <= ram_widx_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_wmask_q  <= ram_wmask_d;
        end
    end

    // Enables are masked by rst_n so a reset landing mid-beat never commits a write.
    assign ram_ren    = ram_ren_q & rst_n;
    assign ram_wen    = ram_wen_q & rst_n;
    assign ram_rIdx   = ram_ridx_q;
    assign ram_wIdx   = ram_widx_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_wmask  = ram_wmask_q;
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: expected RAM beats and responses are queued
// by the directed stimulus and popped by independent monitors.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen, req_signed;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        ram_ren, ram_wen;
    logic [63:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;

    logic [63:0] mem [0:7];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        wen;
        logic [63:0] idx;
        logic [63:0] data;
        logic [63:0] mask;
    } beat_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    beat_t bq[$];
    resp_t rq[$];
    beat_t mb;
    resp_t mr;

    dmem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_ren    (ram_ren),
        .ram_rIdx   (ram_rIdx),
        .ram_rdata  (ram_rdata),
        .ram_wIdx   (ram_wIdx),
        .ram_wdata  (ram_wdata),
        .ram_wmask  (ram_wmask),
        .ram_wen    (ram_wen)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, masked write on the posedge.
    assign ram_rdata = mem[ram_rIdx[2:0]];
    always @(posedge clk) begin
        if (ram_wen)
            mem[ram_wIdx[2:0]] <= (mem[ram_wIdx[2:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic void exp_rd(input logic [63:0] idx);
        beat_t b;
        b.wen = 1'b0; b.idx = idx; b.data = '0; b.mask = '0;
        bq.push_back(b);
    endfunction

    function automatic void exp_wr(input logic [63:0] idx, input logic [63:0] data, input logic [63:0] mask);
        beat_t b;
        b.wen = 1'b1; b.idx = idx; b.data = data; b.mask = mask;
        bq.push_back(b);
    endfunction

    function automatic void exp_resp(input logic [63:0] d, input logic e);
        resp_t r;
        r.rdata = d; r.err = e;
        rq.push_back(r);
    endfunction

    // RAM beat monitor
    always @(negedge clk) begin
        if (ram_ren || ram_wen) begin
            chk("ren_wen_exclusive", 64'(ram_ren & ram_wen), 64'd0);
            if (bq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got ren=%0d wen=%0d ridx=%h widx=%h expected no beat",
                         ram_ren, ram_wen, ram_rIdx, ram_wIdx);
            end else begin
                mb = bq.pop_front();
                chk("beat_kind", 64'(ram_wen), 64'(mb.wen));
                if (mb.wen) begin
                    chk("ram_wIdx", ram_wIdx, mb.idx);
                    chk("ram_wdata", ram_wdata, mb.data);
                    chk("ram_wmask", ram_wmask, mb.mask);
                end else begin
                    chk("ram_rIdx", ram_rIdx, mb.idx);
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (resp_valid && resp_ready) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata=%h err=%0d expected none", resp_rdata, resp_err);
            end else begin
                mr = rq.pop_front();
                chk("resp_rdata", resp_rdata, mr.rdata);
                chk("resp_err", 64'(resp_err), 64'(mr.err));
            end
        end
    end

    // Present one request, wait for acceptance, then measure cycles to resp_valid.
    task automatic issue(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wdata, input int want_lat, input string name);
        logic rdy;
        int   lat;
        req_wen = wen; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wdata;
        req_valid = 1'b1;
        rdy = 1'b0;
        for (int k = 0; k < 10 && !rdy; k++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL %s_accept: got req_ready=0 expected 1 within 10 cycles", name);
            return;
        end
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (resp_valid) lat = k;
        end
        chk({name, "_latency"}, 64'(lat), 64'(want_lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    initial begin
        mem[0] = 64'h1122_3344_5566_7788;
        mem[1] = 64'h99AA_BBCC_DDEE_FF00;
        for (int i = 2; i < 8; i++) mem[i] = 64'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
        req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_ram_en", 64'({ram_ren, ram_wen}), 64'd0);
        chk("rst_ram_buses", ram_rIdx | ram_wIdx | ram_wdata | ram_wmask, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Aligned and misaligned non-crossing loads
        exp_rd(0); exp_resp(64'h1122_3344_5566_7788, 1'b0);
        issue(1'b0, 64'h8000_0000, 2'd3, 1'b0, '0, 2, "ld0");
        exp_rd(0); exp_resp(64'hFFFF_FFFF_FFFF_FF88, 1'b0);
        issue(1'b0, 64'h8000_0000, 2'd0, 1'b1, '0, 2, "lb0");
        exp_rd(0); exp_resp(64'h0000_0000_0000_0088, 1'b0);
        issue(1'b0, 64'h8000_0000, 2'd0, 1'b0, '0, 2, "lbu0");
        exp_rd(0); exp_resp(64'h0000_0000_0000_1122, 1'b0);
        issue(1'b0, 64'h8000_0006, 2'd1, 1'b1, '0, 2, "lh6");
        exp_rd(1); exp_resp(64'hFFFF_FFFF_DDEE_FF00, 1'b0);
        issue(1'b0, 64'h8000_0008, 2'd2, 1'b1, '0, 2, "lw8");
        exp_rd(1); exp_resp(64'h0000_0000_DDEE_FF00, 1'b0);
        issue(1'b0, 64'h8000_0008, 2'd2, 1'b0, '0, 2, "lwu8");
        exp_rd(0); exp_resp(64'h0000_0000_0000_4455, 1'b0);
        issue(1'b0, 64'h8000_0003, 2'd1, 1'b0, '0, 2, "lhu3");

        // Single-beat halfword store, then read back
        exp_wr(0, 64'h0000_0000_ABCD_0000, 64'h0000_0000_FFFF_0000); exp_resp(64'd0, 1'b0);
        issue(1'b1, 64'h8000_0002, 2'd1, 1'b0, 64'hABCD, 2, "sh2");
        exp_rd(0); exp_resp(64'h1122_3344_ABCD_7788, 1'b0);
        issue(1'b0, 64'h8000_0000, 2'd3, 1'b0, '0, 2, "ld0_after_sh");

        // Word-crossing accesses
`ifdef DMEM_MISALIGN_SPLIT_EN
        exp_wr(0, 64'hBEEF_0000_0000_0000, 64'hFFFF_0000_0000_0000);
        exp_wr(1, 64'h0000_0000_0000_DEAD, 64'h0000_0000_0000_FFFF);
        exp_resp(64'd0, 1'b0);
        issue(1'b1, 64'h8000_0006, 2'd2, 1'b0, 64'hDEAD_BEEF, 3, "sw6_split");
        exp_rd(0); exp_rd(1); exp_resp(64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
        issue(1'b0, 64'h8000_0006, 2'd2, 1'b1, '0, 3, "lw6_split");
        exp_rd(1); exp_resp(64'h99AA_BBCC_DDEE_DEAD, 1'b0);
        issue(1'b0, 64'h8000_0008, 2'd3, 1'b0, '0, 2, "ld8");
`else
        exp_resp(64'd0, 1'b1);
        issue(1'b1, 64'h8000_0006, 2'd2, 1'b0, 64'hDEAD_BEEF, 1, "sw6_reject");
        exp_resp(64'd0, 1'b1);
        issue(1'b0, 64'h8000_0006, 2'd2, 1'b1, '0, 1, "lw6_reject");
        exp_rd(1); exp_resp(64'h99AA_BBCC_DDEE_FF00, 1'b0);
        issue(1'b0, 64'h8000_0008, 2'd3, 1'b0, '0, 2, "ld8");
`endif

        // Addresses below the RAM window
        exp_resp(64'd0, 1'b1);
        issue(1'b0, 64'h7FFF_FFFF, 2'd0, 1'b1, '0, 1, "lb_below");
        exp_resp(64'd0, 1'b1);
        issue(1'b1, 64'h7000_0000, 2'd3, 1'b0, 64'h1234, 1, "sd_below");

        // Full doubleword store and sub-word loads of it
        exp_wr(2, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF); exp_resp(64'd0, 1'b0);
        issue(1'b1, 64'h8000_0010, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 2, "sd16");
        exp_rd(2); exp_resp(64'h0000_0000_0000_0001, 1'b0);
        issue(1'b0, 64'h8000_0017, 2'd0, 1'b1, '0, 2, "lb23");
        exp_rd(2); exp_resp(64'hFFFF_FFFF_FFFF_CDEF, 1'b0);
        issue(1'b0, 64'h8000_0010, 2'd1, 1'b1, '0, 2, "lh16");

`ifdef DMEM_MISALIGN_SPLIT_EN
        exp_rd(1); exp_rd(2); exp_resp(64'h89AB_CDEF_99AA_BBCC, 1'b0);
        issue(1'b0, 64'h8000_000C, 2'd3, 1'b0, '0, 3, "ld12_split");
`else
        exp_resp(64'd0, 1'b1);
        issue(1'b0, 64'h8000_000C, 2'd3, 1'b0, '0, 1, "ld12_reject");
`endif

        // Response back-pressure: everything holds while resp_ready is low
        resp_ready = 1'b0;
        exp_rd(0); exp_resp(64'h0000_0000_0000_0088, 1'b0);
        issue(1'b0, 64'h8000_0000, 2'd0, 1'b0, '0, 2, "lbu_stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_resp_valid", 64'(resp_valid), 64'd1);
            chk("stall_resp_rdata", resp_rdata, 64'h88);
            chk("stall_resp_err", 64'(resp_err), 64'd0);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_stall_req_ready", 64'(req_ready), 64'd1);
        chk("after_stall_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset during the first store beat: nothing commits, nothing responds
        req_wen = 1'b1; req_signed = 1'b0; req_valid = 1'b1;
`ifdef DMEM_MISALIGN_SPLIT_EN
        req_addr = 64'h8000_001E; req_size = 2'd2; req_wdata = 64'hCAFE_F00D;
`else
        req_addr = 64'h8000_0018; req_size = 2'd3; req_wdata = 64'hCAFE_F00D_1234_5678;
`endif
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ram_wen", 64'(ram_wen), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_mem3", mem[3], 64'd0);
        chk("midrst_mem4", mem[4], 64'd0);

        exp_rd(2); exp_resp(64'h0123_4567_89AB_CDEF, 1'b0);
        issue(1'b0, 64'h8000_0010, 2'd3, 1'b0, '0, 2, "ld16_after_rst");

        repeat (2) @(posedge clk);
        chk("beat_queue_empty", 64'(bq.size()), 64'd0);
        chk("resp_queue_empty", 64'(rq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
